// File: rtl/ct_ifu_ibuf_ptr_ctrl_pkg.sv
// Shared constants and one-hot rotate helper for the IFU instruction buffer pointer logic.
package ct_ifu_ibuf_ptr_ctrl_pkg;

    localparam int ENTRY_NUM  = 32;
    localparam int CREATE_MAX = 8;
    localparam int RETIRE_MAX = 8;
    localparam int CNT_W      = 6;
    localparam int NUM_W      = 4;
    localparam int IDX_W      = $clog2(ENTRY_NUM);

    // Rotate left by n positions; n must be below ENTRY_NUM.
    function automatic logic [ENTRY_NUM-1:0] rotl_onehot(
        input logic [ENTRY_NUM-1:0] vec,
        input logic [IDX_W-1:0]     n
    );
        logic [2*ENTRY_NUM-1:0] dbl;
        dbl = {vec, vec} << n;
        return dbl[2*ENTRY_NUM-1:ENTRY_NUM];
    endfunction

endpackage

// File: rtl/ct_ifu_ibuf_run_mask.sv
// Builds a run of run_len consecutive set bits beginning at a one-hot start, wrapping around.
module ct_ifu_ibuf_run_mask
    import ct_ifu_ibuf_ptr_ctrl_pkg::*;
(
    input  logic [ENTRY_NUM-1:0] start_onehot,
    input  logic [NUM_W-1:0]     run_len,
    output logic [ENTRY_NUM-1:0] run_mask
);

    logic [ENTRY_NUM-1:0] base_mask;
    logic [IDX_W-1:0]     start_idx;

    genvar gi;
    generate
        for (gi = 0; gi < ENTRY_NUM; gi++) begin : g_base
            localparam logic [IDX_W:0] POS = (IDX_W+1)'(gi);
            assign base_mask[gi] = POS < (IDX_W+1)'(run_len);
        end
    endgenerate

    always_comb begin
        start_idx = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (start_onehot[i]) begin
                start_idx = start_idx | IDX_W'(i);
            end
        end
    end

    assign run_mask = rotl_onehot(base_mask, start_idx);

endmodule

// File: rtl/ct_ifu_ibuf_ptr_ctrl.sv
// IFU instruction buffer pointer/occupancy controller.
// Optional protocol checking is compiled in with CT_IFU_IBUF_PTR_CHECK_EN.
module ct_ifu_ibuf_ptr_ctrl
    import ct_ifu_ibuf_ptr_ctrl_pkg::*;
(
    input  logic                 ibuf_entry_vld_clk,
    input  logic                 cpurst_b,
    input  logic                 ibuf_flush,
    input  logic                 create_vld,
    input  logic [NUM_W-1:0]     create_num,
    input  logic                 retire_vld,
    input  logic [NUM_W-1:0]     retire_num,
    output logic                 create_accept,
    output logic [ENTRY_NUM-1:0] entry_create_x,
    output logic [ENTRY_NUM-1:0] entry_retire_x,
    output logic [ENTRY_NUM-1:0] create_ptr,
    output logic [ENTRY_NUM-1:0] retire_ptr,
    output logic [CNT_W-1:0]     entry_cnt,
    output logic                 ibuf_full,
    output logic                 ibuf_empty,
    output logic                 ptr_clk_en,
    output logic                 ibuf_ptr_err
);

    localparam logic [ENTRY_NUM-1:0] PTR_INIT = ENTRY_NUM'(1);

    logic [ENTRY_NUM-1:0] create_ptr_reg, create_ptr_next;
    logic [ENTRY_NUM-1:0] retire_ptr_reg, retire_ptr_next;
    logic [CNT_W-1:0]     entry_cnt_reg,  entry_cnt_next;
    logic [CNT_W-1:0]     free_cnt;
    logic [NUM_W-1:0]     create_eff;
    logic [NUM_W-1:0]     retire_clip;
    logic [NUM_W-1:0]     retire_eff;

    // Free space is taken before this cycle's retire so the accept path never sees the retire side.
    assign free_cnt      = CNT_W'(ENTRY_NUM) - entry_cnt_reg;
    assign create_accept = cpurst_b & create_vld & ~ibuf_flush
                         & (CNT_W'(create_num) <= free_cnt);
    assign create_eff    = create_accept ? create_num : '0;

    assign retire_clip = (CNT_W'(retire_num) > entry_cnt_reg) ? entry_cnt_reg[NUM_W-1:0]
                                                                : retire_num;
    assign retire_eff  = (cpurst_b & retire_vld & ~ibuf_flush) ? retire_clip : '0;

    ct_ifu_ibuf_run_mask u_create_mask (
        .start_onehot (create_ptr_reg),
        .run_len      (create_eff),
        .run_mask     (entry_create_x)
    );

    ct_ifu_ibuf_run_mask u_retire_mask (
        .start_onehot (retire_ptr_reg),
        .run_len      (retire_eff),
        .run_mask     (entry_retire_x)
    );

    always_comb begin
        create_ptr_next = rotl_onehot(create_ptr_reg, IDX_W'(create_eff));
        retire_ptr_next = rotl_onehot(retire_ptr_reg, IDX_W'(retire_eff));
        entry_cnt_next  = entry_cnt_reg + CNT_W'(create_eff) - CNT_W'(retire_eff);
        if (ibuf_flush) begin
            create_ptr_next = PTR_INIT;
            retire_ptr_next = PTR_INIT;
            entry_cnt_next  = '0;
        end
    end

    always_ff @(posedge ibuf_entry_vld_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            create_ptr_reg <= PTR_INIT;
            retire_ptr_reg <= PTR_INIT;
            entry_cnt_reg  <= '0;
        end else begin
            create_ptr_reg <= create_ptr_next;
            retire_ptr_reg <= retire_ptr_next;
            entry_cnt_reg  <= entry_cnt_next;
        end
    end

    assign create_ptr = create_ptr_reg;
    assign retire_ptr = retire_ptr_reg;
    assign entry_cnt  = entry_cnt_reg;
    assign ibuf_empty = (entry_cnt_reg == '0);
    assign ibuf_full  = free_cnt < CNT_W'(CREATE_MAX);
    assign ptr_clk_en = create_vld | retire_vld | ibuf_flush;

`ifdef CT_IFU_IBUF_PTR_CHECK_EN
    logic ptr_err_reg;
    logic ptr_err_set;

    assign ptr_err_set = (retire_vld & (CNT_W'(retire_num) > entry_cnt_reg))
                       | (create_num > NUM_W'(CREATE_MAX))
                       | (retire_num > NUM_W'(RETIRE_MAX));

    // Sticky until flush so software/debug can observe a past violation.
    always_ff @(posedge ibuf_entry_vld_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ptr_err_reg <= 1'b0;
        end else if (ibuf_flush) begin
            ptr_err_reg <= 1'b0;
        end else if (ptr_err_set) begin
            ptr_err_reg <= 1'b1;
        end
    end

    assign ibuf_ptr_err = ptr_err_reg;
`else
    assign ibuf_ptr_err = 1'b0;
`endif

endmodule

// File: tb/tb_ct_ifu_ibuf_ptr_ctrl.sv
// Self-checking bench for ct_ifu_ibuf_ptr_ctrl: directed vector table, reset sequence, randomized model phase.
module tb_ct_ifu_ibuf_ptr_ctrl;

`ifdef CT_IFU_IBUF_PTR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        cpurst_b;
    logic        ibuf_flush, create_vld, retire_vld;
    logic [3:0]  create_num, retire_num;
    logic        create_accept, ibuf_full, ibuf_empty, ptr_clk_en, ibuf_ptr_err;
    logic [31:0] entry_create_x, entry_retire_x, create_ptr, retire_ptr;
    logic [5:0]  entry_cnt;

    always #5 clk = ~clk;

    ct_ifu_ibuf_ptr_ctrl dut (
        .ibuf_entry_vld_clk (clk),
        .cpurst_b           (cpurst_b),
        .ibuf_flush         (ibuf_flush),
        .create_vld         (create_vld),
        .create_num         (create_num),
        .retire_vld         (retire_vld),
        .retire_num         (retire_num),
        .create_accept      (create_accept),
        .entry_create_x     (entry_create_x),
        .entry_retire_x     (entry_retire_x),
        .create_ptr         (create_ptr),
        .retire_ptr         (retire_ptr),
        .entry_cnt          (entry_cnt),
        .ibuf_full          (ibuf_full),
        .ibuf_empty         (ibuf_empty),
        .ptr_clk_en         (ptr_clk_en),
        .ibuf_ptr_err       (ibuf_ptr_err)
    );

    typedef struct {
        logic [5:0]  cnt;
        logic [31:0] cptr, rptr, cx, rx;
        logic        acc, full, empty, err;
    } exp_t;

    typedef struct {
        logic       cv, rv, fl;
        logic [3:0] cn, rn;
        int         cnt, cidx, ridx;
        logic       acc;
        logic [31:0] cx, rx;
        logic       full, empty, err;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[28];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   txn = 0;

    int   m_cnt, m_c, m_r;
    logic m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic cv, input int cn, input logic rv, input int rn, input logic fl,
                                input int cnt, input int cidx, input int ridx, input logic acc,
                                input logic [31:0] cx, input logic [31:0] rx,
                                input logic full, input logic empty, input logic err);
        vec_t v;
        v.cv = cv; v.cn = 4'(cn); v.rv = rv; v.rn = 4'(rn); v.fl = fl;
        v.cnt = cnt; v.cidx = cidx; v.ridx = ridx; v.acc = acc;
        v.cx = cx; v.rx = rx; v.full = full; v.empty = empty; v.err = err & CHK;
        return v;
    endfunction

    // Drive one cycle, queue its expectation, then compare at the falling edge.
    task automatic apply(input logic cv, input logic [3:0] cn, input logic rv, input logic [3:0] rn,
                         input logic fl, input exp_t e);
        exp_t g;
        @(posedge clk);
        #1;
        create_vld = cv; create_num = cn; retire_vld = rv; retire_num = rn; ibuf_flush = fl;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard: got empty queue, expected entry");
        end else begin
            g = sb_q.pop_front();
            check("entry_cnt",      32'(entry_cnt),      32'(g.cnt));
            check("create_ptr",     create_ptr,          g.cptr);
            check("retire_ptr",     retire_ptr,          g.rptr);
            check("create_accept",  32'(create_accept),  32'(g.acc));
            check("entry_create_x", entry_create_x,      g.cx);
            check("entry_retire_x", entry_retire_x,      g.rx);
            check("ibuf_full",      32'(ibuf_full),      32'(g.full));
            check("ibuf_empty",     32'(ibuf_empty),     32'(g.empty));
            check("ibuf_ptr_err",   32'(ibuf_ptr_err),   32'(g.err));
            check("ptr_clk_en",     32'(ptr_clk_en),     32'(cv | rv | fl));
        end
        $display("txn %0d: cv=%0b cn=%0d rv=%0b rn=%0d fl=%0b cnt=%0d acc=%0b cx=%08h rx=%08h",
                 txn, cv, cn, rv, rn, fl, entry_cnt, create_accept, entry_create_x, entry_retire_x);
        txn++;
    endtask

    // Index-based reference: expectation from current state, then advance.
    task automatic model_step(input logic cv, input int cn, input logic rv, input int rn,
                              input logic fl, output exp_t e);
        int ce, re;
        e.cnt = 6'(m_cnt);
        e.cptr = 32'd1 << m_c;
        e.rptr = 32'd1 << m_r;
        e.acc = cv && !fl && (cn <= 32 - m_cnt);
        ce = e.acc ? cn : 0;
        re = (rv && !fl) ? ((rn < m_cnt) ? rn : m_cnt) : 0;
        e.cx = '0;
        e.rx = '0;
        for (int k = 0; k < ce; k++) e.cx[(m_c + k) % 32] = 1'b1;
        for (int k = 0; k < re; k++) e.rx[(m_r + k) % 32] = 1'b1;
        e.full = (32 - m_cnt) < 8;
        e.empty = (m_cnt == 0);
        e.err = m_err;
        if (fl) begin
            m_cnt = 0; m_c = 0; m_r = 0; m_err = 1'b0;
        end else begin
            if (CHK && rv && rn > m_cnt) m_err = 1'b1;
            m_cnt = m_cnt + ce - re;
            m_c = (m_c + ce) % 32;
            m_r = (m_r + re) % 32;
        end
    endtask

    initial begin
        exp_t e;
        int   cn, rn;
        logic cv, rv, fl;

        tbl[0]  = mk(1,5,0,0,0,  0, 0, 0,1,32'h0000001F,32'h00000000,0,1,0);
        tbl[1]  = mk(0,0,0,0,0,  5, 5, 0,0,32'h00000000,32'h00000000,0,0,0);
        tbl[2]  = mk(1,5,1,5,0,  5, 5, 0,1,32'h000003E0,32'h0000001F,0,0,0);
        tbl[3]  = mk(0,0,1,5,0,  5,10, 5,0,32'h00000000,32'h000003E0,0,0,0);
        tbl[4]  = mk(1,8,1,0,0,  0,10,10,1,32'h0003FC00,32'h00000000,0,1,0);
        tbl[5]  = mk(0,0,1,8,0,  8,18,10,0,32'h00000000,32'h0003FC00,0,0,0);
        tbl[6]  = mk(1,8,0,0,0,  0,18,18,1,32'h03FC0000,32'h00000000,0,1,0);
        tbl[7]  = mk(0,0,1,8,0,  8,26,18,0,32'h00000000,32'h03FC0000,0,0,0);
        tbl[8]  = mk(1,4,0,0,0,  0,26,26,1,32'h3C000000,32'h00000000,0,1,0);
        tbl[9]  = mk(0,0,1,4,0,  4,30,26,0,32'h00000000,32'h3C000000,0,0,0);
        tbl[10] = mk(1,4,0,0,0,  0,30,30,1,32'hC0000003,32'h00000000,0,1,0);
        tbl[11] = mk(1,6,0,0,0,  4, 2,30,1,32'h000000FC,32'h00000000,0,0,0);
        tbl[12] = mk(1,8,1,6,0, 10, 8,30,1,32'h0000FF00,32'hC000000F,0,0,0);
        tbl[13] = mk(0,0,0,0,0, 12,16, 4,0,32'h00000000,32'h00000000,0,0,0);
        tbl[14] = mk(1,8,0,0,0, 12,16, 4,1,32'h00FF0000,32'h00000000,0,0,0);
        tbl[15] = mk(1,6,0,0,0, 20,24, 4,1,32'h3F000000,32'h00000000,0,0,0);
        tbl[16] = mk(1,8,0,0,0, 26,30, 4,0,32'h00000000,32'h00000000,1,0,0);
        tbl[17] = mk(0,0,1,8,0, 26,30, 4,0,32'h00000000,32'h00000FF0,1,0,0);
        tbl[18] = mk(1,8,0,0,0, 18,30,12,1,32'hC000003F,32'h00000000,0,0,0);
        tbl[19] = mk(1,6,0,0,0, 26, 6,12,1,32'h00000FC0,32'h00000000,1,0,0);
        tbl[20] = mk(1,0,0,0,0, 32,12,12,1,32'h00000000,32'h00000000,1,0,0);
        tbl[21] = mk(1,1,0,0,0, 32,12,12,0,32'h00000000,32'h00000000,1,0,0);
        tbl[22] = mk(1,8,1,8,1, 32,12,12,0,32'h00000000,32'h00000000,1,0,0);
        tbl[23] = mk(1,3,0,0,0,  0, 0, 0,1,32'h00000007,32'h00000000,0,1,0);
        tbl[24] = mk(0,0,1,6,0,  3, 3, 0,0,32'h00000000,32'h00000007,0,0,0);
        tbl[25] = mk(0,0,0,0,0,  0, 3, 3,0,32'h00000000,32'h00000000,0,1,1);
        tbl[26] = mk(0,0,0,0,1,  0, 3, 3,0,32'h00000000,32'h00000000,0,1,1);
        tbl[27] = mk(0,0,0,0,0,  0, 0, 0,0,32'h00000000,32'h00000000,0,1,0);

        cpurst_b = 1'b0;
        ibuf_flush = 1'b0; create_vld = 1'b1; create_num = 4'd3; retire_vld = 1'b1; retire_num = 4'd2;
        repeat (2) @(negedge clk);
        check("rst create_ptr",    create_ptr,              32'h1);
        check("rst retire_ptr",    retire_ptr,              32'h1);
        check("rst entry_cnt",     32'(entry_cnt),          32'd0);
        check("rst create_accept", 32'(create_accept),      32'd0);
        check("rst create_x",      entry_create_x,          32'd0);
        check("rst retire_x",      entry_retire_x,          32'd0);
        check("rst empty",         32'(ibuf_empty),         32'd1);
        check("rst full",          32'(ibuf_full),          32'd0);
        check("rst err",           32'(ibuf_ptr_err),       32'd0);
        create_vld = 1'b0; retire_vld = 1'b0; create_num = '0; retire_num = '0;
        cpurst_b = 1'b1;

        for (int i = 0; i < 28; i++) begin
            e.cnt = 6'(tbl[i].cnt);
            e.cptr = 32'd1 << tbl[i].cidx;
            e.rptr = 32'd1 << tbl[i].ridx;
            e.acc = tbl[i].acc; e.cx = tbl[i].cx; e.rx = tbl[i].rx;
            e.full = tbl[i].full; e.empty = tbl[i].empty; e.err = tbl[i].err;
            apply(tbl[i].cv, tbl[i].cn, tbl[i].rv, tbl[i].rn, tbl[i].fl, e);
        end

        // Asynchronous reset in the middle of a burst.
        m_cnt = 0; m_c = 0; m_r = 0; m_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model_step(1'b1, 5, 1'b1, 2, 1'b0, e);
            apply(1'b1, 4'd5, 1'b1, 4'd2, 1'b0, e);
        end
        @(posedge clk);
        #1;
        create_vld = 1'b1; create_num = 4'd4; retire_vld = 1'b1; retire_num = 4'd2; ibuf_flush = 1'b0;
        #2;
        cpurst_b = 1'b0;
        #1;
        check("arst create_ptr",    create_ptr,           32'h1);
        check("arst retire_ptr",    retire_ptr,           32'h1);
        check("arst entry_cnt",     32'(entry_cnt),       32'd0);
        check("arst create_accept", 32'(create_accept),   32'd0);
        check("arst create_x",      entry_create_x,       32'd0);
        check("arst retire_x",      entry_retire_x,       32'd0);
        check("arst empty",         32'(ibuf_empty),      32'd1);
        @(negedge clk);
        create_vld = 1'b0; retire_vld = 1'b0; create_num = '0; retire_num = '0;
        cpurst_b = 1'b1;
        m_cnt = 0; m_c = 0; m_r = 0; m_err = 1'b0;

        for (int i = 0; i < 200; i++) begin
            cv = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            cn = int'($urandom_range(0, 8));
            rn = int'($urandom_range(0, 8));
            fl = ($urandom_range(0, 19) == 0);
            model_step(cv, cn, rv, rn, fl, e);
            apply(cv, 4'(cn), rv, 4'(rn), fl, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ct_ifu_ibuf_ptr_ctrl.md
Name: ct_ifu_ibuf_ptr_ctrl

Overview:
Pointer and occupancy controller for the IFU instruction buffer, a circular array of half-word entries.
- Upstream: accepts up to CREATE_MAX half-words per cycle from the IP/predecode stage.
- Downstream: accepts up to RETIRE_MAX half-words per cycle consumed by the decode/pop side.
- Generates per-entry one-hot create/retire strobes that drive each buffer entry's create/retire and clock-enable inputs.
- Tracks occupancy and produces the full/empty status used for fetch backpressure.

Parameters:
ENTRY_NUM, 32, number of half-word entries; power of 2, 8..64.
CREATE_MAX, 8, maximum half-words written per cycle.
RETIRE_MAX, 8, maximum half-words retired per cycle.
CNT_W, 6, occupancy counter width; equals log2(ENTRY_NUM)+1.

Ports:
ibuf_entry_vld_clk  in  1  gated clock; ICG enable is ptr_clk_en.
cpurst_b  in  1  reset, asynchronous, active-low.
ibuf_flush  in  1  flush the buffer.
create_vld  in  1  upstream requests a write.
create_num  in  4  half-words to write, 0..CREATE_MAX.
retire_vld  in  1  downstream requests a retire.
retire_num  in  4  half-words to retire, 0..RETIRE_MAX.
create_accept  out  1  write accepted this cycle.
entry_create_x  out  ENTRY_NUM  one-hot-run create strobe per entry.
entry_retire_x  out  ENTRY_NUM  one-hot-run retire strobe per entry.
create_ptr  out  ENTRY_NUM  one-hot write pointer (registered).
retire_ptr  out  ENTRY_NUM  one-hot read pointer (registered).
entry_cnt  out  CNT_W  valid entry count (registered).
ibuf_full  out  1  free entries < CREATE_MAX.
ibuf_empty  out  1  entry_cnt == 0.
ptr_clk_en  out  1  create_vld | retire_vld | ibuf_flush; drives the upstream ICG.
ibuf_ptr_err  out  1  sticky protocol-error flag (see Optional Feature).

Behaviour:
- Reset values: create_ptr = retire_ptr = bit0 set; entry_cnt = 0; ibuf_ptr_err = 0.
- Combinational outputs under reset: entry_create_x = entry_retire_x = 0; create_accept = 0; ibuf_empty = 1; ibuf_full = 0.
- Free count: free = ENTRY_NUM - entry_cnt.
- Retire:
  - retire_eff = retire_vld ? min(retire_num, entry_cnt) : 0.
  - Only entries already valid at the cycle start may retire; there is no same-cycle create-to-retire bypass.
- Create:
  - create_accept = create_vld & !ibuf_flush & (create_num <= free).
  - free is sampled before this cycle's retire, so the check is conservative and has no timing path from the retire side.
  - create_eff = create_accept ? create_num : 0.
- Strobes (combinational, same cycle):
  - entry_create_x sets create_eff consecutive bits starting at create_ptr, wrapping modulo ENTRY_NUM.
  - entry_retire_x sets retire_eff bits starting at retire_ptr in the same way.
  - Because create only writes free slots, the two vectors never overlap.
- Next state on the clock edge:
  - create_ptr rotates left by create_eff.
  - retire_ptr rotates left by retire_eff.
  - entry_cnt <= entry_cnt + create_eff - retire_eff.
  - The counter never exceeds ENTRY_NUM and never underflows.
- Full/empty boundaries:
  - When entry_cnt == ENTRY_NUM, the pointers are equal and ibuf_full = 1.
  - When entry_cnt == 0, the pointers are equal and ibuf_empty = 1.
  - Full and empty are distinguished by entry_cnt, never by pointer comparison.
- Zero-count requests: create_num = 0 or retire_num = 0 are legal no-ops; create_accept is still 1 when create_vld is set.
- Flush (priority over create and retire):
  - Same cycle: both strobe vectors are 0.
  - Next edge: pointers return to bit0 and entry_cnt returns to 0.
- Reset asserted mid-operation forces the reset values asynchronously, including clearing the pointers.
- Latency: strobes are combinational; pointer and count updates are visible 1 cycle later.

Optional Feature:
Macro CT_IFU_IBUF_PTR_CHECK_EN.
- Defined: ibuf_ptr_err is set on the next edge when any of these occurs:
  - retire_vld with retire_num > entry_cnt;
  - create_num > CREATE_MAX;
  - retire_num > RETIRE_MAX.
- Defined: ibuf_ptr_err is sticky and cleared only by ibuf_flush or reset.
- Not defined: ibuf_ptr_err is tied to 0 and no check logic is synthesised.
- Clipping of retire_eff applies in both builds.

Decomposition:
- Shared package: ENTRY_NUM, CREATE_MAX, RETIRE_MAX, CNT_W constants, plus a rotate-by-N function for one-hot vectors.
- One natural sub-module: ct_ifu_ibuf_run_mask, which takes a one-hot start and a count and produces the wrapped run mask. It is instantiated twice, once for create and once for retire.

Test Plan:
- Reset, then create_vld with create_num = 5 → entry_create_x = 0x0000001F, create_accept = 1; next cycle create_ptr = bit5, entry_cnt = 5.
- Wrap-around:
  - Preload create_ptr = retire_ptr = bit30 with entry_cnt = 0.
  - create 4 → entry_create_x = 0xC0000003; next cycle create_ptr = bit2, entry_cnt = 4.
- Simultaneous create and retire:
  - With entry_cnt = 10, create 8 and retire 6 in the same cycle.
  - Retire strobes cover 6 entries from retire_ptr; next cycle entry_cnt = 12 and ibuf_full = 0.
- Full buffer:
  - With entry_cnt = 26, create 8 → create_accept = 0, entry_create_x = 0, ibuf_full = 1.
  - Retire 8 → entry_cnt = 18, and the next create 8 is accepted.
- Flush with create and retire active → both strobes 0 in that cycle; next cycle both pointers = bit0 and entry_cnt = 0. Asynchronous reset mid-burst gives the same pointer and count result.
- Over-retire: with entry_cnt = 3, retire 6 → entry_retire_x has 3 bits set and entry_cnt = 0.
  - With CT_IFU_IBUF_PTR_CHECK_EN defined: ibuf_ptr_err = 1 until the next flush.
  - Without it: ibuf_ptr_err stays 0.
